// File: rtl/key_dir_debounce.sv
// key_dir_debounce: synchronises and debounces four direction keys, emits press pulses and
// manages the committed snake heading. Optional auto-repeat is built when KEY_REPEAT_EN is defined.
module key_dir_debounce #(
  parameter int         DEB_CYCLES     = 1000000,
  parameter bit         KEY_ACTIVE_LOW = 1'b1,
  parameter logic [1:0] INIT_DIR       = 2'd3
`ifdef KEY_REPEAT_EN
  ,
  parameter int         REPEAT_CYCLES  = 25000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       k_up,
  input  logic       k_down,
  input  logic       k_left,
  input  logic       k_right,
  input  logic       step_tick,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [1:0] dir,
  output logic [1:0] dir_pending,
  output logic       any_press
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  function automatic dir_e opposite(input dir_e d);
    case (d)
      DIR_UP:   opposite = DIR_DOWN;
      DIR_DOWN: opposite = DIR_UP;
      DIR_LEFT: opposite = DIR_RIGHT;
      default:  opposite = DIR_LEFT;
    endcase
  endfunction

  // Key vectors are ordered {up, down, left, right}; 1 = pressed after normalisation.
  logic [3:0] key_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] level_q, level_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] arm_q, arm_d;
  logic [1:0] settle_q, settle_d;
  logic [3:0] press_q, press_d;
  logic       any_q, any_d;
  logic [CNT_W-1:0] deb_cnt_q [4];
  logic [CNT_W-1:0] deb_cnt_d [4];
  dir_e       dir_q, dir_d;
  dir_e       pend_q, pend_d;
  logic [3:0] rise_edge;
  logic [3:0] rise;
  logic       req_valid;
  dir_e       req_dir;
  logic       req_ok;

`ifdef KEY_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt_q [4];
  logic [REP_W-1:0] rep_cnt_d [4];
  logic [3:0]       rep_fire;
`endif

  assign key_raw = KEY_ACTIVE_LOW ? ~{k_up, k_down, k_left, k_right}
                                  :  {k_up, k_down, k_left, k_right};

  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    prev_d   = level_q;
    settle_d = {settle_q[0], 1'b1};
    level_d  = level_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i] = '0;
        level_d[i]   = sync2_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
    // A key only becomes eligible for pulses once it has been seen released after reset.
    arm_d = arm_q | ({4{settle_q[1]}} & ~sync2_q);
  end

  assign rise_edge = level_q & ~prev_q;
  assign rise      = rise_edge & arm_q;

`ifdef KEY_REPEAT_EN
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 4; i++) begin
      if (!level_q[i] || rise_edge[i]) begin
        rep_cnt_d[i] = '0;
      end else if (rep_cnt_q[i] == REP_LAST) begin
        rep_cnt_d[i] = '0;
        rep_fire[i]  = arm_q[i];
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
      end
    end
  end

  assign press_d = rise | rep_fire;
`else
  assign press_d = rise;
`endif

  assign any_d = |press_d;

  // Requests come from the registered pulses; up > down > left > right.
  always_comb begin
    req_valid = |press_q;
    if (press_q[3])      req_dir = DIR_UP;
    else if (press_q[2]) req_dir = DIR_DOWN;
    else if (press_q[1]) req_dir = DIR_LEFT;
    else                 req_dir = DIR_RIGHT;
    req_ok = req_valid && (req_dir != opposite(dir_q));
    pend_d = req_ok ? req_dir : pend_q;
    dir_d  = step_tick ? pend_d : dir_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      prev_q   <= '0;
      arm_q    <= '0;
      settle_q <= '0;
      press_q  <= '0;
      any_q    <= 1'b0;
      dir_q    <= dir_e'(INIT_DIR);
      pend_q   <= dir_e'(INIT_DIR);
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= '0;
`ifdef KEY_REPEAT_EN
        rep_cnt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      prev_q   <= prev_d;
      arm_q    <= arm_d;
      settle_q <= settle_d;
      press_q  <= press_d;
      any_q    <= any_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
`ifdef KEY_REPEAT_EN
        rep_cnt_q[i] <= rep_cnt_d[i];
`endif
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign any_press   = any_q;
  assign dir         = dir_q;
  assign dir_pending = pend_q;

endmodule
